// File: rtl/mul36_share_arb.sv
// rtl/mul36_share_arb.sv - two-requester arbiter sharing one registered 36x36 multiplier.
// Define MUL36_SHARE_ARB_RR_EN for round-robin contention; fixed priority (req0) otherwise.
module mul36_share_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [35:0] req0_a,
    input  logic [35:0] req0_b,
    input  logic        req0_a_signed,
    input  logic        req0_b_signed,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [35:0] req1_a,
    input  logic [35:0] req1_b,
    input  logic        req1_a_signed,
    input  logic        req1_b_signed,
    output logic [35:0] mul_a,
    output logic [35:0] mul_b,
    output logic        mul_a_signed,
    output logic        mul_b_signed,
    output logic        mul_ce_in,
    output logic        mul_ce_out,
    output logic        mul_rst,
    input  logic [71:0] mul_z,
    output logic        res_valid,
    output logic        res_id,
    output logic [71:0] res_z
);
    logic s1_v_q, s1_id_q, s1_as_q, s1_bs_q;
    logic s2_v_q, s2_id_q;
    logic hold_v_q, hold_id_q;
    logic mul_rst_q;

    logic both_v, any_v, prio, win, win_as, win_bs, hazard, grant;

`ifdef MUL36_SHARE_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign prio  = ptr_q;
    assign ptr_d = (grant & both_v) ? ~win : ptr_q;
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        both_v = req0_valid & req1_valid;
        any_v  = req0_valid | req1_valid;
        // A requester stalled by a signedness hazard keeps the grant for the following cycle.
        if (hold_v_q && (hold_id_q ? req1_valid : req0_valid)) begin
            win = hold_id_q;
        end else if (both_v) begin
            win = prio;
        end else begin
            win = ~req0_valid;
        end
        win_as = win ? req1_a_signed : req0_a_signed;
        win_bs = win ? req1_b_signed : req0_b_signed;
        // SIGNEDA/B feed the multiply stage, so they must stay with the op in stage1.
        hazard = s1_v_q & ((win_as != s1_as_q) | (win_bs != s1_bs_q));
        grant  = any_v & ~hazard & ~mul_rst_q;
    end

    always_comb begin
        req0_ready = grant & ~win;
        req1_ready = grant & win;
        mul_ce_in  = grant;
        mul_a      = '0;
        mul_b      = '0;
        if (grant) begin
            mul_a = win ? req1_a : req0_a;
            mul_b = win ? req1_b : req0_b;
        end
        if (grant) begin
            mul_a_signed = win_as;
            mul_b_signed = win_bs;
        end else if (s1_v_q) begin
            mul_a_signed = s1_as_q;
            mul_b_signed = s1_bs_q;
        end else begin
            mul_a_signed = 1'b0;
            mul_b_signed = 1'b0;
        end
        mul_ce_out = s1_v_q;
        mul_rst    = mul_rst_q;
        res_valid  = s2_v_q;
        res_id     = s2_id_q;
        res_z      = s2_v_q ? mul_z : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_id_q   <= 1'b0;
            s1_as_q   <= 1'b0;
            s1_bs_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_id_q   <= 1'b0;
            hold_v_q  <= 1'b0;
            hold_id_q <= 1'b0;
            mul_rst_q <= 1'b1;
        end else begin
            s1_v_q    <= grant;
            s1_id_q   <= win;
            s1_as_q   <= win_as;
            s1_bs_q   <= win_bs;
            s2_v_q    <= s1_v_q;
            s2_id_q   <= s1_id_q;
            hold_v_q  <= any_v & hazard & ~mul_rst_q;
            hold_id_q <= win;
            mul_rst_q <= 1'b0;
        end
    end

`ifdef MUL36_SHARE_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_mul36_share_arb.sv
// tb/tb_mul36_share_arb.sv - self-checking bench for mul36_share_arb with a behavioural multiplier.
`timescale 1ns/1ps
module tb_mul36_share_arb;
`ifdef MUL36_SHARE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [71:0] NEG15 = -72'sd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v, rdy, sa, sb;
    logic [35:0] a [2];
    logic [35:0] b [2];
    logic [35:0] mul_a, mul_b;
    logic        mul_a_signed, mul_b_signed, mul_ce_in, mul_ce_out, mul_rst;
    logic [71:0] mul_z, res_z;
    logic        res_valid, res_id;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mul36_share_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req0_a_signed(sa[0]), .req0_b_signed(sb[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_a(a[1]), .req1_b(b[1]),
        .req1_a_signed(sa[1]), .req1_b_signed(sb[1]),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
        .mul_ce_in(mul_ce_in), .mul_ce_out(mul_ce_out), .mul_rst(mul_rst), .mul_z(mul_z),
        .res_valid(res_valid), .res_id(res_id), .res_z(res_z)
    );

    function automatic logic [71:0] prod(input logic [35:0] x, input logic [35:0] y,
                                         input logic xs, input logic ys);
        logic [73:0] ex, ey, p;
        ex = {{38{xs & x[35]}}, x};
        ey = {{38{ys & y[35]}}, y};
        p  = ex * ey;
        return p[71:0];
    endfunction

    // Multiplier primitive: registered inputs, signedness applied in the multiply stage.
    logic [35:0] ma_q, mb_q;
    always @(posedge clk) begin
        if (mul_rst) begin
            ma_q  <= '0;
            mb_q  <= '0;
            mul_z <= '0;
        end else begin
            if (mul_ce_in) begin
                ma_q <= mul_a;
                mb_q <= mul_b;
            end
            if (mul_ce_out) mul_z <= prod(ma_q, mb_q, mul_a_signed, mul_b_signed);
        end
    end

    typedef struct {int id; logic [71:0] z; int due;} res_t;
    res_t q[$];
    int cyc = 0;
    int m_last_v = 0, m_last_as = 0, m_last_bs = 0, m_ptr = 0, m_hold = -1, m_inrst = 1;

    function automatic int winner();
        if (!v[0] && !v[1]) return -1;
        if (m_hold >= 0 && v[m_hold]) return m_hold;
        if (v[0] && v[1]) return RR ? m_ptr : 0;
        return v[0] ? 0 : 1;
    endfunction

    function automatic int exp_grant();
        int w;
        w = winner();
        if (rst || m_inrst != 0 || w < 0) return -1;
        if (m_last_v != 0 && (int'(sa[w]) != m_last_as || int'(sb[w]) != m_last_bs)) return -1;
        return w;
    endfunction

    initial forever begin
        int g, w;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_last_v = 0; m_ptr = 0; m_hold = -1; m_inrst = 1;
            q.delete();
        end else begin
            w = winner();
            g = exp_grant();
            if (g >= 0) q.push_back('{g, prod(a[g], b[g], sa[g], sb[g]), cyc + 2});
            if (g >= 0 && v[0] && v[1] && RR) m_ptr = 1 - g;
            m_hold = (g < 0 && w >= 0 && m_inrst == 0) ? w : -1;
            m_last_v = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                m_last_as = int'(sa[g]);
                m_last_bs = int'(sb[g]);
            end
            m_inrst = 0;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v = 2'b00;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        v = 2'b11; sa = 2'b00; sb = 2'b00;
        a[0] = 36'd0; b[0] = 36'd0; a[1] = 36'd0; b[1] = 36'd0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({rdy, mul_ce_in, mul_ce_out, res_valid, res_id, res_z, mul_rst} !== {2'b00, 4'b0000, 72'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ce_in=%b ce_out=%b rv=%b id=%b z=%h mrst=%b, want all 0 and mul_rst=1",
                     rdy, mul_ce_in, mul_ce_out, res_valid, res_id, res_z, mul_rst);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mul_rst, rdy} !== 3'b100) begin
            errors++;
            $display("FAIL release_before_edge: got mul_rst=%b rdy=%b want 1 00", mul_rst, rdy);
        end
        tick();
        v = 2'b01;
        @(negedge clk);
        checks++;
        if ({mul_rst, rdy} !== 3'b001) begin
            errors++;
            $display("FAIL first_grant_after_release: got mul_rst=%b rdy=%b want 0 01", mul_rst, rdy);
        end
        tick();
        v = 2'b00;
    endtask

    task automatic test_single();
        v = 2'b01; a[0] = 36'd3; b[0] = 36'hFFFFFFFFB; sa[0] = 1'b1; sb[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy, mul_ce_in, mul_a, mul_b, mul_a_signed, mul_b_signed} !== {2'b01, 1'b1, 36'd3, 36'hFFFFFFFFB, 2'b11}) begin
            errors++;
            $display("FAIL single_issue: got rdy=%b ce=%b a=%h b=%h s=%b%b", rdy, mul_ce_in, mul_a, mul_b, mul_a_signed, mul_b_signed);
        end
        tick();
        v = 2'b00;
        @(negedge clk);
        checks++;
        if ({res_valid, mul_ce_out} !== 2'b01) begin
            errors++;
            $display("FAIL single_t1: got res_valid=%b ce_out=%b want 0 1", res_valid, mul_ce_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_z} !== {1'b1, 1'b0, NEG15}) begin
            errors++;
            $display("FAIL single_result: got v=%b id=%b z=%h want 1 0 %h", res_valid, res_id, res_z, NEG15);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_streaming();
        logic [35:0] ops [4];
        logic [71:0] exp_z [4];
        ops   = '{36'd1, 36'd2, 36'd3, 36'hFFFFFFFFF};
        exp_z = '{72'd1, 72'd4, 72'd9, 72'hFFFFFFFFE000000001};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                v = 2'b10; a[1] = ops[i]; b[1] = ops[i]; sa[1] = 1'b0; sb[1] = 1'b0;
            end else begin
                v = 2'b00;
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (rdy !== 2'b10) begin
                    errors++;
                    $display("FAIL stream_ready[%0d]: got %b want 10", i, rdy);
                end
            end
            if (i >= 2 && i < 6) begin
                checks++;
                if ({res_valid, res_id, res_z} !== {1'b1, 1'b1, exp_z[i-2]}) begin
                    errors++;
                    $display("FAIL stream_result[%0d]: got v=%b id=%b z=%h want 1 1 %h", i - 2, res_valid, res_id, res_z, exp_z[i-2]);
                end
            end
            if (i == 6) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_end: got res_valid=%b want 0", res_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        int k [2];
        int got_id [16];
        logic [71:0] got_z [16];
        int cnt, j0, j1, eid;
        logic [1:0] hs;
        logic [71:0] ez;
        k = '{0, 0};
        cnt = 0;
        sa = 2'b00; sb = 2'b00;
        for (int c = 0; c < 14; c++) begin
            for (int n = 0; n < 2; n++) begin
                v[n] = (k[n] < 4);
                a[n] = 36'(n * 16 + k[n] + 1);
                b[n] = 36'd3;
            end
            @(negedge clk);
            hs = rdy & v;
            if (res_valid === 1'b1 && cnt < 16) begin
                got_id[cnt] = int'(res_id);
                got_z[cnt]  = res_z;
                cnt++;
            end
            tick();
            for (int n = 0; n < 2; n++) if (hs[n]) k[n]++;
        end
        v = 2'b00;
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL contention_count: got %0d results want 8", cnt);
        end
        j0 = 0; j1 = 0;
        for (int i = 0; i < 8 && i < cnt; i++) begin
            eid = RR ? (i % 2) : (i / 4);
            checks++;
            if (got_id[i] != eid) begin
                errors++;
                $display("FAIL contention_id[%0d]: got %0d want %0d", i, got_id[i], eid);
            end
            ez = (eid == 0) ? 72'((j0 + 1) * 3) : 72'((16 + j1 + 1) * 3);
            if (eid == 0) j0++; else j1++;
            checks++;
            if (got_z[i] !== ez) begin
                errors++;
                $display("FAIL contention_z[%0d]: got %h want %h", i, got_z[i], ez);
            end
        end
    endtask

    task automatic test_hazard();
        v = 2'b01; a[0] = 36'd5; b[0] = 36'd7; sa[0] = 1'b0; sb[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 2'b01) begin
            errors++;
            $display("FAIL hazard_first_ready: got %b want 01", rdy);
        end
        tick();
        a[0] = 36'hFFFFFFFFF; b[0] = 36'hFFFFFFFFF; sa[0] = 1'b1; sb[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy, mul_ce_in, mul_ce_out, mul_a_signed, mul_b_signed} !== {2'b00, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL hazard_stall: got rdy=%b ce_in=%b ce_out=%b s=%b%b want 00 0 1 00", rdy, mul_ce_in, mul_ce_out, mul_a_signed, mul_b_signed);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rdy, res_valid, res_z} !== {2'b01, 1'b1, 72'd35}) begin
            errors++;
            $display("FAIL hazard_resume: got rdy=%b v=%b z=%h want 01 1 23", rdy, res_valid, res_z);
        end
        tick();
        v = 2'b00;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hazard_gap: got res_valid=%b want 0", res_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_z} !== {1'b1, 1'b0, 72'd1}) begin
            errors++;
            $display("FAIL hazard_signed_result: got v=%b id=%b z=%h want 1 0 1", res_valid, res_id, res_z);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        v = 2'b01; a[0] = 36'd6; b[0] = 36'd7; sa[0] = 1'b0; sb[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 2'b01) begin
            errors++;
            $display("FAIL midrst_handshake: got %b want 01", rdy);
        end
        tick();
        v = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mul_rst, res_valid, mul_ce_out} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_assert: got mul_rst=%b v=%b ce_out=%b want 1 0 0", mul_rst, res_valid, mul_ce_out);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mul_rst, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_release: got mul_rst=%b v=%b want 1 0", mul_rst, res_valid);
        end
        tick();
        v = 2'b01; a[0] = 36'd9; b[0] = 36'd11;
        @(negedge clk);
        checks++;
        if ({mul_rst, res_valid, rdy} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_no_ghost: got mul_rst=%b v=%b rdy=%b want 0 0 01", mul_rst, res_valid, rdy);
        end
        tick();
        v = 2'b00;
        tick();
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_z} !== {1'b1, 1'b0, 72'd99}) begin
            errors++;
            $display("FAIL midrst_next_op: got v=%b id=%b z=%h want 1 0 63", res_valid, res_id, res_z);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] hs, erdy;
        logic [63:0] r;
        int g;
        logic ev;
        idle(3);
        q.delete();
        hs = 2'b00;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] || hs[n]) begin
                    if (i < 392 && $urandom_range(0, 3) != 0) begin
                        v[n] = 1'b1;
                        r = {$urandom, $urandom};
                        a[n] = ($urandom_range(0, 4) == 0) ? 36'hFFFFFFFFF : r[35:0];
                        b[n] = ($urandom_range(0, 4) == 0) ? 36'h800000000 : r[63:28];
                        if ($urandom_range(0, 2) == 0) begin
                            sa[n] = 1'($urandom_range(0, 1));
                            sb[n] = 1'($urandom_range(0, 1));
                        end
                    end else begin
                        v[n] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            g = exp_grant();
            erdy = 2'b00;
            if (g >= 0) erdy[g] = 1'b1;
            checks++;
            if (rdy !== erdy) begin
                errors++;
                $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, rdy, erdy);
            end
            ev = (q.size() > 0 && q[0].due == cyc);
            checks++;
            if (res_valid !== ev) begin
                errors++;
                $display("FAIL rand_res_valid cyc %0d: got %b want %b", cyc, res_valid, ev);
            end
            if (ev) begin
                checks++;
                if ({res_id, res_z} !== {1'(q[0].id), q[0].z}) begin
                    errors++;
                    $display("FAIL rand_result cyc %0d: got id=%b z=%h want id=%0d z=%h", cyc, res_id, res_z, q[0].id, q[0].z);
                end
                void'(q.pop_front());
            end
            hs = rdy & v;
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d outstanding results want 0", q.size());
        end
    endtask

    initial begin
        v = 2'b00; sa = 2'b00; sb = 2'b00;
        a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
        test_reset();
        idle(3);
        test_single();
        idle(3);
        test_streaming();
        idle(3);
        test_contention();
        idle(3);
        test_hazard();
        idle(3);
        test_reset_mid();
        idle(3);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
